// File: rtl/divisor_iterativo.sv
// rtl/divisor_iterativo.sv - multi-cycle radix-2 restoring integer divider
// Works on operand magnitudes; sign correction is applied when loading q/r.
module divisor_iterativo #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             signed_op,
   input  logic             clear,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             done,
   output logic             div_by_zero,
   output logic             busy,
   output logic             stall
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   dvd_q, dvd_d;
   logic [WIDTH-1:0]   dsr_q, dsr_d;
   logic               qneg_q, qneg_d;
   logic               rneg_q, rneg_d;
   logic [WIDTH-1:0]   q_q, q_d;
   logic [WIDTH-1:0]   r_q, r_d;
   logic               dbz_q, dbz_d;

   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     shifted, trial;
   logic               trial_ok;
   logic [WIDTH-1:0]   rem_next, quo_next;

   // The dividend register doubles as the quotient: its MSB feeds the
   // partial remainder while the new quotient bit enters at the LSB.
   always_comb begin
      a_mag    = (signed_op & a[WIDTH-1]) ? -a : a;
      b_mag    = (signed_op & b[WIDTH-1]) ? -b : b;
      shifted  = {rem_q, dvd_q[WIDTH-1]};
      trial    = shifted - {1'b0, dsr_q};
      trial_ok = ~trial[WIDTH];
      rem_next = trial_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
      quo_next = {dvd_q[WIDTH-2:0], trial_ok};
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      dvd_d   = dvd_q;
      dsr_d   = dsr_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      q_d     = q_q;
      r_d     = r_q;
      dbz_d   = dbz_q;
      if (clear) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  qneg_d = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                  rneg_d = signed_op & a[WIDTH-1];
                  rem_d  = '0;
                  dvd_d  = a_mag;
                  dsr_d  = b_mag;
                  cnt_d  = '0;
                  if (b == '0) begin
                     state_d = DONE;
                     q_d     = '1;
                     r_d     = a;
                     dbz_d   = 1'b1;
                  end else begin
                     state_d = CALC;
                     dbz_d   = 1'b0;
                  end
               end
            end
            CALC: begin
               rem_d = rem_next;
               dvd_d = quo_next;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  state_d = DONE;
                  q_d     = qneg_q ? -quo_next : quo_next;
                  r_d     = rneg_q ? -rem_next : rem_next;
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         dvd_q   <= '0;
         dsr_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         q_q     <= '0;
         r_q     <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         dvd_q   <= dvd_d;
         dsr_q   <= dsr_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         q_q     <= q_d;
         r_q     <= r_d;
         dbz_q   <= dbz_d;
      end
   end

   assign q           = q_q;
   assign r           = r_q;
   assign done        = (state_q == DONE);
   assign div_by_zero = dbz_q & done;
   assign busy        = (state_q != IDLE);
   assign stall       = ((state_q == IDLE) & start & ~clear) | (state_q == CALC);

endmodule

// File: doc/divisor_iterativo.md
# divisor_iterativo

Multi-cycle radix-2 restoring integer divider for the execute stage of the pipelined core. It takes operands from the ID/EX pipeline register and produces quotient and remainder after a fixed number of cycles. While it works, it drives a stall signal into the enable inputs of the upstream pipeline registers. Its result is consumed by the EX/MEM register in the cycle `done` is high.

## Interface
- `WIDTH`, default 32: operand, quotient and remainder width in bits (≥ 2).
- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `start`  input  1  request a division; sampled only in IDLE.
- `signed_op`  input  1  1 = two's-complement division, 0 = unsigned; sampled with `start`.
- `clear`  input  1  synchronous abort (pipeline flush); returns the block to IDLE.
- `a`  input  WIDTH  dividend; sampled with `start`.
- `b`  input  WIDTH  divisor; sampled with `start`.
- `q`  output  WIDTH  quotient; registered; valid while `done` = 1.
- `r`  output  WIDTH  remainder; registered; valid while `done` = 1.
- `done`  output  1  one-cycle result-valid pulse.
- `div_by_zero`  output  1  high together with `done` when `b` was 0.
- `busy`  output  1  high when state ≠ IDLE.
- `stall`  output  1  combinational: (IDLE & `start` & ~`clear`) | CALC; holds the upstream pipeline registers.

## Operation
- States are IDLE, CALC and DONE. Reset state is IDLE. On reset every output register clears to 0, and so do the internal registers.
- **IDLE**
  - With `start` = 1 and `clear` = 0, the block latches the operand magnitudes, the quotient sign (`signed_op` & (a[MSB] ^ b[MSB])) and the remainder sign (`signed_op` & a[MSB]).
  - The partial remainder is cleared and the bit counter is set to 0.
  - Next state is CALC, or DONE directly if `b` = 0.
  - `start` in any state other than IDLE is ignored.
- **CALC**, once per cycle:
  - Shift {partial remainder, dividend} left by 1.
  - Compute trial = partial remainder − |b| at WIDTH+1 bits.
  - If trial ≥ 0, keep the trial value and shift in a quotient bit of 1. Otherwise shift in 0.
  - The counter increments each cycle. After WIDTH iterations the next state is DONE.
- **DONE**, lasts one cycle:
  - `q` and `r` hold the sign-corrected results: negate `q` if the quotient sign is set, negate `r` if the remainder sign is set.
  - `done` = 1. Next state is IDLE.
- Divide by zero: `q` = all ones, `r` = `a` unchanged, `div_by_zero` = 1, no CALC cycles.
- Signed overflow (a = most-negative value, b = −1): `q` = most-negative value, `r` = 0, `div_by_zero` = 0. The magnitude path yields this naturally; no special case is needed.
- `clear` = 1 in any state forces IDLE on the next edge. `done` stays 0 and `q`/`r` keep their previous values. `clear` has priority over `start`.
- Assertion of `reset` at any time, including mid-CALC, immediately forces IDLE with all outputs at 0.
- Arithmetic is modulo 2^WIDTH on outputs. Internal subtraction is WIDTH+1 bits so the borrow is visible.

## Timing
- `start` is sampled at edge E0.
  - Normal case: CALC occupies the cycles after edges E0 … E(WIDTH−1), and `done` is high in the cycle after edge E(WIDTH).
  - Latency is WIDTH+1 cycles from start-sample to `done`; for WIDTH = 32 that is 33.
- Divide by zero: `done` is high in the cycle after E0, so latency is 1.
- `stall` is high from the `start` cycle through the last CALC cycle. It is low in the DONE cycle so the EX/MEM register captures `q`/`r`.
- `busy` is high from the cycle after E0 through the DONE cycle inclusive.
- A new `start` is accepted in the cycle immediately after DONE, which gives back-to-back throughput of one division per WIDTH+2 cycles.

## Test plan
All cases use WIDTH = 32.
- Unsigned 100 / 7 (`signed_op` = 0) → `q` = 14, `r` = 2, `done` high exactly 33 cycles after the start edge, `stall` high for 33 cycles then low.
- Signed −7 / 2 → `q` = 0xFFFFFFFD (−3), `r` = 0xFFFFFFFF (−1). Signed 7 / −2 → `q` = −3, `r` = 1.
- Divide by zero, a = 0x12345678, b = 0 → `done` and `div_by_zero` high 1 cycle after start, `q` = 0xFFFFFFFF, `r` = 0x12345678.
- Signed 0x80000000 / 0xFFFFFFFF → `q` = 0x80000000, `r` = 0, `div_by_zero` = 0. Unsigned 0xFFFFFFFF / 1 → `q` = 0xFFFFFFFF, `r` = 0.
- `clear` pulsed 10 cycles into CALC → IDLE next cycle, `done` never asserts, `stall` and `busy` drop. A following 9 / 3 returns `q` = 3, `r` = 0.
- `reset` asserted mid-CALC → all outputs 0 immediately. `start` pulses during CALC are ignored: the result matches the first operands.
